// File: rtl/fetch_instr_unpacker.sv
// Splits 64-bit instruction FIFO beats into two PC-tagged 32-bit instructions for decode,
// re-aligning on redirects and discarding a programmable number of stale beats.
module fetch_instr_unpacker #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_reset,
  input  logic        rd_empty_i,
  input  logic [63:0] rd_data_i,
  output logic        rd_en_o,
  input  logic        flush_i,
  input  logic [63:0] flush_pc_i,
  input  logic [3:0]  flush_skip_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [63:0] instr_pc_o
);

  logic [63:0] word_q;
  logic        lo_vld_q;
  logic        hi_vld_q;
  logic [63:0] pc_q;
  logic [3:0]  drop_cnt_q;

  logic        fire;
  logic        lo_after;
  logic        hi_after;
  logic        empty_nxt;
  logic        drop_mode;
  logic [63:0] pc_nxt;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^flush_pc_i[1:0];

  assign instr_valid_o = lo_vld_q | hi_vld_q;
  assign instr_o       = lo_vld_q ? word_q[31:0] : word_q[63:32];
  assign instr_pc_o    = pc_q;

  // A fire consumes the lower half first; the upper half only once the lower is gone.
  always_comb begin
    fire      = instr_valid_o & instr_ready_i & ~flush_i;
    lo_after  = lo_vld_q & ~fire;
    hi_after  = hi_vld_q & ~(fire & ~lo_vld_q);
    empty_nxt = ~(lo_after | hi_after);
    drop_mode = (drop_cnt_q != 4'd0);
    pc_nxt    = fire ? (pc_q + 64'd4) : pc_q;
    rd_en_o   = ~cpu_reset & ~rd_empty_i & ~flush_i & (drop_mode | empty_nxt);
  end

  // Popping in the same cycle the last half is accepted keeps decode fed without bubbles.
  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      word_q     <= 64'd0;
      lo_vld_q   <= 1'b0;
      hi_vld_q   <= 1'b0;
      pc_q       <= RESET_PC;
      drop_cnt_q <= 4'd0;
    end else if (flush_i) begin
      lo_vld_q   <= 1'b0;
      hi_vld_q   <= 1'b0;
      pc_q       <= {flush_pc_i[63:2], 2'b00};
      drop_cnt_q <= flush_skip_i;
    end else begin
      lo_vld_q <= lo_after;
      hi_vld_q <= hi_after;
      pc_q     <= pc_nxt;
      if (rd_en_o) begin
        if (drop_mode) begin
          drop_cnt_q <= drop_cnt_q - 4'd1;
        end else begin
          word_q   <= rd_data_i;
          hi_vld_q <= 1'b1;
          lo_vld_q <= ~pc_nxt[2];
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_instr_unpacker.sv
// Randomized and directed bench for fetch_instr_unpacker; a queue of pending
// {instruction, PC} entries stands in for the expected decode stream.
module tb_fetch_instr_unpacker;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  logic        cpu_clk = 1'b0;
  logic        cpu_reset;
  logic        rd_empty;
  logic [63:0] rd_data;
  logic        rd_en;
  logic        flush;
  logic [63:0] flush_pc;
  logic [3:0]  flush_skip;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  int checks = 0;
  int errors = 0;

  logic [63:0] fifo[$];
  ent_t        pend[$];
  logic [63:0] m_pc;
  int          m_drop;

  always #5 cpu_clk = ~cpu_clk;

  fetch_instr_unpacker #(.RESET_PC(RESET_PC)) dut (
    .cpu_clk       (cpu_clk),
    .cpu_reset     (cpu_reset),
    .rd_empty_i    (rd_empty),
    .rd_data_i     (rd_data),
    .rd_en_o       (rd_en),
    .flush_i       (flush),
    .flush_pc_i    (flush_pc),
    .flush_skip_i  (flush_skip),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    pend.delete();
    m_pc   = RESET_PC;
    m_drop = 0;
  endtask

  // One cycle: drive inputs at the falling edge, compare against the stream model,
  // then advance the model with the same inputs the DUT sees at the rising edge.
  task automatic applyStimulus(input bit rdy, input bit stall, input bit fl,
                               input logic [63:0] fpc, input logic [3:0] fskip);
    bit   exp_valid, exp_fire, exp_pop;
    int   remaining;
    logic [63:0] beat;
    @(negedge cpu_clk);
    rd_empty    = stall || (fifo.size() == 0);
    rd_data     = (fifo.size() != 0) ? fifo[0] : {$urandom, $urandom};
    instr_ready = rdy;
    flush       = fl;
    flush_pc    = fpc;
    flush_skip  = fskip;
    #1;
    exp_valid = (pend.size() != 0);
    exp_fire  = exp_valid && rdy && !fl;
    remaining = pend.size() - (exp_fire ? 1 : 0);
    exp_pop   = !rd_empty && !fl && ((m_drop != 0) || (remaining == 0));
    checkOutput("valid", {63'd0, instr_valid}, {63'd0, exp_valid});
    checkOutput("rd_en", {63'd0, rd_en}, {63'd0, exp_pop});
    if (exp_valid) begin
      checkOutput("instr", {32'd0, instr}, {32'd0, pend[0].instr});
      checkOutput("pc", instr_pc, pend[0].pc);
    end else begin
      checkOutput("pc_idle", instr_pc, m_pc);
    end
    @(posedge cpu_clk);
    if (fl) begin
      pend.delete();
      m_pc   = {fpc[63:2], 2'b00};
      m_drop = fskip;
    end else begin
      if (exp_fire) begin
        void'(pend.pop_front());
        m_pc = m_pc + 64'd4;
      end
      if (exp_pop) begin
        beat = fifo.pop_front();
        if (m_drop != 0) begin
          m_drop--;
        end else if (m_pc[2] == 1'b0) begin
          pend.push_back('{beat[31:0], m_pc});
          pend.push_back('{beat[63:32], m_pc + 64'd4});
        end else begin
          pend.push_back('{beat[63:32], m_pc});
        end
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 4'd0);
  endtask

  initial begin
    cpu_reset   = 1'b1;
    rd_empty    = 1'b0;
    rd_data     = 64'hBBBB_BBBB_AAAA_AAAA;
    instr_ready = 1'b1;
    flush       = 1'b0;
    flush_pc    = 64'd0;
    flush_skip  = 4'd0;
    modelReset();
    #3;
    checkOutput("reset_valid", {63'd0, instr_valid}, 64'd0);
    checkOutput("reset_rd_en", {63'd0, rd_en}, 64'd0);
    checkOutput("reset_instr", {32'd0, instr}, 64'd0);
    checkOutput("reset_pc", instr_pc, RESET_PC);
    rd_empty = 1'b1;
    #4 cpu_reset = 1'b0;

    // First beat and back-to-back streaming.
    fifo.push_back(64'hBBBB_BBBB_AAAA_AAAA);
    fifo.push_back(64'h4444_4444_3333_3333);
    fifo.push_back(64'h6666_6666_5555_5555);
    fifo.push_back(64'h8888_8888_7777_7777);
    drain(12);

    // Redirect to an odd-word PC: only the upper half of the first beat is used.
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_0106, 4'd0);
    fifo.push_back(64'h2222_2222_1111_1111);
    fifo.push_back(64'hDDDD_DDDD_CCCC_CCCC);
    drain(6);

    // Skip three stale beats.
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h0000_0000_9000_0000, 4'd3);
    for (int i = 0; i < 5; i++) fifo.push_back({$urandom, $urandom});
    drain(14);

    // Decode stalls with both halves buffered and more data waiting.
    fifo.push_back(64'h1234_5678_9ABC_DEF0);
    fifo.push_back(64'h0FED_CBA9_8765_4321);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    drain(6);

    // Flush colliding with a fire and a pending pop, then back-to-back flushes in drop mode.
    fifo.push_back(64'hAAAA_0001_AAAA_0000);
    fifo.push_back(64'hAAAA_0003_AAAA_0002);
    fifo.push_back(64'hAAAA_0005_AAAA_0004);
    drain(2);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h0000_0000_A000_0000, 4'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h0000_0000_B000_0008, 4'd1);
    fifo.push_back(64'hEEEE_0001_EEEE_0000);
    fifo.push_back(64'hEEEE_0003_EEEE_0002);
    drain(8);

    // PC wrap at the top of the address space.
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 4'd0);
    fifo.push_back(64'h7777_0001_7777_0000);
    fifo.push_back(64'h7777_0003_7777_0002);
    drain(6);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (fifo.size() < 4 && $urandom_range(0, 2) == 0) fifo.push_back({$urandom, $urandom});
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 24) == 0, {$urandom, $urandom},
                    4'($urandom_range(0, 3)));
    end

    // Asynchronous reset mid-stream.
    fifo.push_back({$urandom, $urandom});
    fifo.push_back({$urandom, $urandom});
    drain(2);
    @(negedge cpu_clk);
    #2 cpu_reset = 1'b1;
    #1;
    checkOutput("midreset_rd_en", {63'd0, rd_en}, 64'd0);
    checkOutput("midreset_valid", {63'd0, instr_valid}, 64'd0);
    checkOutput("midreset_pc", instr_pc, RESET_PC);
    modelReset();
    rd_empty = 1'b1;
    flush    = 1'b0;
    @(negedge cpu_clk);
    #2 cpu_reset = 1'b0;
    drain(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
